// File: rtl/gpo_pad_ctrl_pkg.sv
// gpo_pad_ctrl_pkg: shared FSM state, pad mode encodings and default sequencing delays for gpo_pad_ctrl.
package gpo_pad_ctrl_pkg;
  typedef enum logic [1:0] {S_OFF, S_DRAIN, S_BIAS, S_ON} state_t;
  localparam logic [1:0] MODE_PP  = 2'b00;
  localparam logic [1:0] MODE_OD  = 2'b01;
  localparam logic [1:0] MODE_OS  = 2'b10;
  localparam logic [1:0] MODE_PWM = 2'b11;
  localparam int BIAS_WAIT_DEF = 16;
  localparam int OFF_WAIT_DEF  = 4;
endpackage

// File: rtl/gpo_pwm_gen.sv
// gpo_pwm_gen: PWM counter 0..period with duty compare; counter held at 0 while not running.
module gpo_pwm_gen #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         run_i,
  input  logic [W-1:0] period_i,
  input  logic [W-1:0] duty_i,
  output logic         pwm_o
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else cnt <= (!run_i || cnt >= period_i) ? '0 : cnt + 1'b1;
  assign pwm_o = (period_i != '0) && (cnt < duty_i);
endmodule

// File: rtl/gpo_pad_ctrl.sv
// gpo_pad_ctrl: GPIO output pad sequencer (drain / bias-wait / on) with registered pad controls.
// Optional PWM output mode is built only when GPO_PAD_CTRL_PWM_EN is defined.
module gpo_pad_ctrl
  import gpo_pad_ctrl_pkg::*;
#(
  parameter int BIAS_WAIT_CYC = BIAS_WAIT_DEF,
  parameter int OFF_WAIT_CYC  = OFF_WAIT_DEF,
  parameter int PWM_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             data_i,
  input  logic [1:0]       ds_i,
  input  logic             sr_i,
  input  logic             co_i,
  input  logic [1:0]       mode_i,
  input  logic             vbias_ok_i,
  input  logic [PWM_W-1:0] pwm_period_i,
  input  logic [PWM_W-1:0] pwm_duty_i,
  output logic             do_o,
  output logic [1:0]       ds_o,
  output logic             sr_o,
  output logic             co_o,
  output logic             oe_o,
  output logic             odp_o,
  output logic             odn_o,
  output logic             busy_o,
  output logic             fault_o
);
  localparam int MAXW = (BIAS_WAIT_CYC > OFF_WAIT_CYC) ? BIAS_WAIT_CYC : OFF_WAIT_CYC;
  localparam int CW = $clog2(MAXW + 2);
  localparam logic [CW-1:0] BIAS_LD = CW'(BIAS_WAIT_CYC);
  localparam logic [CW-1:0] OFF_LD  = CW'(OFF_WAIT_CYC);
  state_t state, nxt;
  logic [1:0] mode_q, ds_p, mode_p, nxt_ds, nxt_mode, nxt_dsp, nxt_modep;
  logic [CW-1:0] cnt, nxt_cnt;
  logic set_fault, chg, on, drv;
  assign chg = (ds_i != ds_o) || (mode_i != mode_q);
  always_comb begin
    nxt = state;
    nxt_ds = ds_o;
    nxt_mode = mode_q;
    nxt_dsp = ds_p;
    nxt_modep = mode_p;
    nxt_cnt = cnt;
    set_fault = 1'b0;
    if (!en_i) begin
      nxt = S_OFF;
      nxt_cnt = '0;
    end else begin
      unique case (state)
        S_OFF: begin
          nxt_ds = ds_i;
          nxt_mode = mode_i;
          nxt = (ds_i == 2'b00) ? S_ON : S_BIAS;
          nxt_cnt = (ds_i == 2'b00) ? '0 : BIAS_LD;
        end
        S_ON: begin
          if (chg) begin
            nxt = S_DRAIN;
            nxt_dsp = ds_i;
            nxt_modep = mode_i;
            nxt_cnt = OFF_LD;
          end else if (ds_o != 2'b00 && !vbias_ok_i) begin
            set_fault = 1'b1;
            nxt = S_BIAS;
            nxt_cnt = BIAS_LD;
          end
        end
        S_BIAS: begin
          if (chg) begin
            nxt = S_DRAIN;
            nxt_dsp = ds_i;
            nxt_modep = mode_i;
            nxt_cnt = OFF_LD;
          end else if (!vbias_ok_i) nxt_cnt = BIAS_LD;
          else if (cnt <= CW'(1)) begin
            nxt = S_ON;
            nxt_cnt = '0;
          end else nxt_cnt = cnt - 1'b1;
        end
        S_DRAIN: begin
          if (ds_i != ds_p || mode_i != mode_p) begin
            nxt_dsp = ds_i;
            nxt_modep = mode_i;
            nxt_cnt = OFF_LD;
          end else if (cnt <= CW'(1)) begin
            // new drive strength is applied only now, with the pad still disabled
            nxt_ds = ds_p;
            nxt_mode = mode_p;
            nxt = (ds_p == 2'b00) ? S_ON : S_BIAS;
            nxt_cnt = (ds_p == 2'b00) ? '0 : BIAS_LD;
          end else nxt_cnt = cnt - 1'b1;
        end
      endcase
    end
  end
  assign on = (nxt == S_ON);
`ifdef GPO_PAD_CTRL_PWM_EN
  logic pwm;
  gpo_pwm_gen #(.W(PWM_W)) u_pwm (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .run_i(on && nxt_mode == MODE_PWM),
    .period_i(pwm_period_i),
    .duty_i(pwm_duty_i),
    .pwm_o(pwm)
  );
  assign drv = (nxt_mode == MODE_PWM) ? pwm : data_i;
`else
  logic unused_pwm;
  assign unused_pwm = ^{pwm_period_i, pwm_duty_i};
  assign drv = data_i;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= S_OFF;
      mode_q <= MODE_PP;
      ds_p <= 2'b00;
      mode_p <= MODE_PP;
      cnt <= '0;
      ds_o <= 2'b00;
      do_o <= 1'b0;
      sr_o <= 1'b0;
      co_o <= 1'b0;
      oe_o <= 1'b0;
      odp_o <= 1'b0;
      odn_o <= 1'b0;
      busy_o <= 1'b0;
      fault_o <= 1'b0;
    end else begin
      state <= nxt;
      mode_q <= nxt_mode;
      ds_p <= nxt_dsp;
      mode_p <= nxt_modep;
      cnt <= nxt_cnt;
      ds_o <= nxt_ds;
      do_o <= on && drv;
      sr_o <= sr_i;
      co_o <= co_i;
      oe_o <= on;
      odp_o <= on && nxt_mode == MODE_OS;
      odn_o <= on && nxt_mode == MODE_OD;
      busy_o <= (nxt == S_DRAIN) || (nxt == S_BIAS);
      fault_o <= (nxt != S_OFF) && (fault_o || set_fault);
    end
endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// tb_gpo_pad_ctrl: table-driven directed checks plus hand sequences for bias wait, drain, fault, PWM and async reset.
module tb_gpo_pad_ctrl;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, data = 1'b0, sr = 1'b0, co = 1'b0, vb = 1'b0;
  logic [1:0] ds = 2'd0, mode = 2'd0;
  logic [7:0] per = 8'd0, duty = 8'd0;
  logic do_o, sr_o, co_o, oe_o, odp_o, odn_o, busy_o, fault_o;
  logic [1:0] ds_o;
  logic [9:0] outs;
  int errors = 0, checks = 0;
`ifdef GPO_PAD_CTRL_PWM_EN
  localparam logic PWM_ON = 1'b1;
`else
  localparam logic PWM_ON = 1'b0;
`endif
  always #5 clk = ~clk;
  gpo_pad_ctrl dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(data), .ds_i(ds), .sr_i(sr), .co_i(co),
    .mode_i(mode), .vbias_ok_i(vb), .pwm_period_i(per), .pwm_duty_i(duty),
    .do_o(do_o), .ds_o(ds_o), .sr_o(sr_o), .co_o(co_o), .oe_o(oe_o), .odp_o(odp_o),
    .odn_o(odn_o), .busy_o(busy_o), .fault_o(fault_o)
  );
  assign outs = {oe_o, busy_o, do_o, odp_o, odn_o, ds_o, sr_o, co_o, fault_o};
  typedef struct {
    logic en; logic [1:0] ds; logic [1:0] mode; logic d; logic vb; logic sr; logic co;
    logic [9:0] exp;
  } vec_t;
  function automatic vec_t mk(input logic en_, input logic [1:0] ds_, input logic [1:0] md,
                              input logic d, input logic vb_, input logic sr_, input logic co_,
                              input logic oe, input logic bz, input logic dv, input logic op,
                              input logic on_, input logic [1:0] dso);
    vec_t v;
    v.en = en_; v.ds = ds_; v.mode = md; v.d = d; v.vb = vb_; v.sr = sr_; v.co = co_;
    v.exp = {oe, bz, dv, op, on_, dso, sr_, co_, 1'b0};
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  initial begin
    vec_t v[13];
    v[0]  = mk(1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    v[1]  = mk(1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    v[2]  = mk(1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    v[3]  = mk(1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    v[4]  = mk(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    v[5]  = mk(1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    v[6]  = mk(1'b1, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    v[7]  = mk(1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    v[8]  = mk(1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    v[9]  = mk(1'b1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    v[10] = mk(1'b0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    v[11] = mk(1'b1, 2'd0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, !PWM_ON, 1'b0, 1'b0, 2'd0);
    v[12] = mk(1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    // reset holds every output low even with a live request
    en = 1'b1; ds = 2'd2; sr = 1'b1; co = 1'b1; vb = 1'b1;
    tick(); tick();
    chk("reset_outs", outs, 10'd0);
    en = 1'b0; ds = 2'd0; sr = 1'b0; co = 1'b0;
    rst = 1'b0;
    foreach (v[i]) begin
      en = v[i].en; ds = v[i].ds; mode = v[i].mode; data = v[i].d;
      vb = v[i].vb; sr = v[i].sr; co = v[i].co;
      tick();
      chk($sformatf("vec%0d", i), outs, v[i].exp);
    end
    // bias wait with steady vbias
    sr = 1'b0; co = 1'b0; data = 1'b0; mode = 2'd0; vb = 1'b1; en = 1'b1; ds = 2'd2;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bias_busy%0d", i), {7'd0, oe_o, busy_o, fault_o}, 10'b010);
      tick();
    end
    chk("bias_on", {6'd0, oe_o, busy_o, ds_o}, 10'b1010);
    // bias wait restarts after vbias drop
    en = 1'b0; tick();
    en = 1'b1; tick();
    repeat (5) tick();
    vb = 1'b0;
    repeat (3) tick();
    chk("bias_drop_busy", {8'd0, oe_o, busy_o}, 10'b01);
    vb = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("bias_restart%0d", i), {8'd0, oe_o, busy_o}, 10'b01);
    end
    tick();
    chk("bias_restart_on", {8'd0, oe_o, busy_o}, 10'b10);
    // reconfiguration drain then bias
    en = 1'b0; tick();
    en = 1'b1; ds = 2'd0; tick();
    chk("recfg_on", {6'd0, oe_o, busy_o, ds_o}, 10'b1000);
    ds = 2'd3; tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), {6'd0, oe_o, busy_o, ds_o}, 10'b0100);
      tick();
    end
    chk("drain_done", {6'd0, oe_o, busy_o, ds_o}, 10'b0111);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("recfg_bias%0d", i), {8'd0, oe_o, busy_o}, 10'b01);
    end
    tick();
    chk("recfg_final", {6'd0, oe_o, busy_o, ds_o}, 10'b1011);
    // bias loss in ON
    en = 1'b0; tick();
    en = 1'b1; ds = 2'd1; tick();
    repeat (16) tick();
    chk("fault_pre", {6'd0, oe_o, fault_o, ds_o}, 10'b1001);
    vb = 1'b0; tick();
    chk("fault_set", {7'd0, oe_o, busy_o, fault_o}, 10'b011);
    en = 1'b0; tick();
    chk("fault_clr", {7'd0, oe_o, busy_o, fault_o}, 10'b000);
    vb = 1'b1;
`ifdef GPO_PAD_CTRL_PWM_EN
    en = 1'b1; ds = 2'd0; mode = 2'd3; per = 8'd9; duty = 8'd3;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("pwm%0d", k), {9'd0, do_o}, {9'd0, ((k % 10) < 3)});
    end
    duty = 8'd0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("pwm_duty0_%0d", k), {9'd0, do_o}, 10'd0);
    end
    duty = 8'd3; per = 8'd0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("pwm_per0_%0d", k), {9'd0, do_o}, 10'd0);
    end
    en = 1'b0; mode = 2'd0; tick();
`else
    // PWM config must be ignored: mode 11 is push-pull
    en = 1'b1; ds = 2'd0; mode = 2'd3; per = 8'd9; duty = 8'd3;
    for (int k = 0; k < 6; k++) begin
      data = k[0];
      tick();
      chk($sformatf("nopwm%0d", k), {7'd0, do_o, odp_o, odn_o}, {7'd0, k[0], 2'b00});
    end
    en = 1'b0; mode = 2'd0; tick();
`endif
    // asynchronous reset mid-bias
    en = 1'b1; ds = 2'd2; sr = 1'b1; co = 1'b1; tick();
    repeat (3) tick();
    chk("arst_pre", {6'd0, busy_o, sr_o, ds_o}, 10'b1110);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("arst_outs", outs, 10'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    chk("arst_reseq", {6'd0, oe_o, busy_o, ds_o}, 10'b0110);
    repeat (16) tick();
    chk("arst_on", {8'd0, oe_o, busy_o}, 10'b10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
